load_store_unit: RTL and testbench

Memory-access stage of the RV32I core. It consumes the execute-stage result: the ALU output is the effective address, and rs2 is the store data. The unit issues a single request to data memory over a grant/rvalid handshake. For loads, it aligns and sign- or zero-extends the returned data. Each instruction ends with one registered response pulse toward writeback; non-memory instructions pass the ALU result through.

---
 rtl/load_store_unit_pkg.sv | 61 ++++++
 rtl/load_store_unit_align.sv | 26 ++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    function automatic logic [3:0] lsu_be(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_wdata(
        input logic [2:0]  f3,
        input logic [31:0] d
    );
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Illegal width encoding or address not aligned to the access size.
    function automatic logic lsu_bad(
        input logic       is_load,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic ill;
        logic mis;
        ill = is_load ? (f3 == 3'b011 || f3[2:1] == 2'b11)
                      : (f3 >= 3'b011);
        mis = (f3[1:0] == 2'b01 && off[0])
           || (f3[1:0] == 2'b10 && off != 2'b00);
        return ill || mis;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load lane select and sign/zero extension.
import load_store_unit_pkg::*;

module load_align (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = w_sh;
        case (i_funct3)
            MEM_B:   o_data = {{24{w_sh[7]}}, w_sh[7:0]};
            MEM_H:   o_data = {{16{w_sh[15]}}, w_sh[15:0]};
            MEM_BU:  o_data = {24'd0, w_sh[7:0]};
            MEM_HU:  o_data = {16'd0, w_sh[15:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one dmem request per load/store.
import load_store_unit_pkg::*;

module load_store_unit #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] store_data_i,
    output logic              resp_valid_o,
    output logic [DWIDTH-1:0] resp_data_o,
    output logic              err_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              r_store;
    logic [2:0]        r_f3;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_sdata;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_in_load;
    logic              w_in_store;
    logic              w_in_mem;
    logic              w_in_bad;
    logic              w_go_mem;
    logic              w_issue;
    logic [DWIDTH-1:0] w_load_data;

    assign w_in_load  = (opcode_i == OPCODE_LOAD);
    assign w_in_store = (opcode_i == OPCODE_STORE);
    assign w_in_mem   = w_in_load || w_in_store;
    assign w_in_bad   = lsu_bad(w_in_load, funct3_i, addr_i[1:0]);
    assign w_go_mem   = w_in_mem && !w_in_bad;
    assign w_accept   = req_valid_i && (r_state == IDLE) && !reset;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_go_mem ? REQ : RESP;
            REQ:  if (dmem_gnt_i) w_next = r_store ? RESP : WAIT;
            WAIT: if (dmem_rvalid_i) w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_store <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_sdata <= '0;
        end else if (w_accept) begin
            r_store <= w_in_store;
            r_f3    <= funct3_i;
            r_addr  <= addr_i;
            r_sdata <= store_data_i;
        end
    end

    load_align u_align (
        .i_rdata  (dmem_rdata_i),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_f3),
        .o_data   (w_load_data)
    );

    // Response data/err are loaded on entry to RESP and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept && !w_go_mem) begin
            r_rdata <= w_in_mem ? '0 : addr_i;
            r_err   <= w_in_mem;
        end else if (r_state == REQ && dmem_gnt_i && r_store) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == WAIT && dmem_rvalid_i) begin
            r_rdata <= w_load_data;
            r_err   <= 1'b0;
        end
    end

    assign w_issue      = (r_state == REQ) && !reset;
    assign req_ready_o  = reset || (r_state == IDLE);
    assign resp_valid_o = (r_state == RESP) && !reset;
    assign resp_data_o  = reset ? '0 : r_rdata;
    assign err_o        = r_err && !reset;

    assign dmem_req_o   = w_issue;
    assign dmem_we_o    = w_issue && r_store;
    assign dmem_addr_o  = w_issue ? {r_addr[AWIDTH-1:2], 2'b00} : '0;
    assign dmem_be_o    = w_issue ? lsu_be(r_f3, r_addr[1:0]) : 4'b0000;
    assign dmem_wdata_o = (w_issue && r_store)
                        ? lsu_wdata(r_f3, r_sdata) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized checks of load_store_unit against a reference model.
module tb_load_store_unit;

    localparam logic [6:0] OP_LD = 7'h03;
    localparam logic [6:0] OP_ST = 7'h23;
    localparam logic [6:0] OP_OP = 7'h33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    int checks = 0;
    int failures = 0;
    int n_gnt = 0;

    load_store_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .err_o        (err_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (dmem_req_o && dmem_gnt_i) n_gnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // {err, data} the unit should report for one instruction.
    function automatic logic [32:0] ref_resp(
        input logic [6:0] op, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] rdata
    );
        int unsigned sz, off;
        logic        ill;
        logic [31:0] v;
        if (op != OP_LD && op != OP_ST) return {1'b0, addr};
        if (op == OP_LD) ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
        else             ill = (f3 >= 3);
        sz  = acc_size(f3);
        off = addr % 4;
        if (ill || (addr % sz) != 0) return {1'b1, 32'd0};
        if (op == OP_ST) return {1'b0, 32'd0};
        v = rdata >> (8 * off);
        if (sz == 1) begin
            v = v % 256;
            if (f3 == 0 && v >= 128) v = v - 256;
        end else if (sz == 2) begin
            v = v % 65536;
            if (f3 == 1 && v >= 32768) v = v - 65536;
        end
        return {1'b0, v};
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3,
                                           input logic [31:0] addr);
        int unsigned off;
        off = addr % 4;
        if (acc_size(f3) == 1) return 32'd1 << off;
        if (acc_size(f3) == 2) return (off >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3,
                                              input logic [31:0] d);
        if (acc_size(f3) == 1) return (d % 256) * 32'h0101_0101;
        if (acc_size(f3) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    task automatic do_txn(
        input logic [6:0] op, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] rs2,
        input logic [31:0] rdata, input int gd, input int rd
    );
        logic [32:0] r;
        logic        is_mem, is_st, go;
        r      = ref_resp(op, f3, addr, rdata);
        is_st  = (op == OP_ST);
        is_mem = (op == OP_LD) || is_st;
        go     = is_mem && !r[32];
        chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i  = 1'b1;
        opcode_i     = op;
        funct3_i     = f3;
        addr_i       = addr;
        store_data_i = rs2;
        step();
        req_valid_i  = 1'b0;
        opcode_i     = 7'($urandom);
        addr_i       = $urandom;
        store_data_i = $urandom;
        if (!go) begin
            chk("fast_valid", {31'd0, resp_valid_o}, 32'd1);
            chk("fast_err", {31'd0, err_o}, {31'd0, r[32]});
            chk("fast_data", resp_data_o, r[31:0]);
            chk("fast_noreq", {31'd0, dmem_req_o}, 32'd0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                dmem_gnt_i = (i == gd);
                if (!is_st) begin
                    dmem_rvalid_i = 1'($urandom);
                    dmem_rdata_i  = $urandom;
                end
                chk("req", {31'd0, dmem_req_o}, 32'd1);
                chk("we", {31'd0, dmem_we_o}, {31'd0, is_st});
                chk("addr", dmem_addr_o, addr - (addr % 4));
                chk("be", {28'd0, dmem_be_o}, ref_be(f3, addr));
                if (is_st) chk("wdata", dmem_wdata_o, ref_wdata(f3, rs2));
                chk("early_valid", {31'd0, resp_valid_o}, 32'd0);
                step();
            end
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (!is_st) begin
                for (int i = 0; i < rd; i++) begin
                    chk("wait_valid", {31'd0, resp_valid_o}, 32'd0);
                    chk("wait_noreq", {31'd0, dmem_req_o}, 32'd0);
                    step();
                end
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rdata;
                step();
                dmem_rvalid_i = 1'b0;
                dmem_rdata_i  = $urandom;
            end
            chk("mem_valid", {31'd0, resp_valid_o}, 32'd1);
            chk("mem_err", {31'd0, err_o}, 32'd0);
            chk("mem_data", resp_data_o, r[31:0]);
            chk("mem_noreq", {31'd0, dmem_req_o}, 32'd0);
        end
        step();
        chk("pulse_end", {31'd0, resp_valid_o}, 32'd0);
        chk("ready_back", {31'd0, req_ready_o}, 32'd1);
        chk("hold_data", resp_data_o, r[31:0]);
        chk("hold_err", {31'd0, err_o}, {31'd0, r[32]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        logic [31:0] y;
        logic [6:0]  op;
        logic [31:0] a;

        // Reset with a request offered that must be ignored.
        req_valid_i = 1'b1;
        opcode_i    = OP_OP;
        addr_i      = 32'h55;
        #1;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst_data", resp_data_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        step();
        step();
        reset       = 1'b0;
        req_valid_i = 1'b0;
        step();
        chk("post_rst_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);

        do_txn(OP_OP, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 0, 0);
        do_txn(OP_ST, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 0);
        do_txn(OP_LD, 3'd0, 32'h0000_2002, 32'h0, 32'h0080_0000, 3, 1);
        do_txn(OP_LD, 3'd4, 32'h0000_2002, 32'h0, 32'h0080_0000, 3, 1);
        do_txn(OP_LD, 3'd2, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
        do_txn(OP_ST, 3'd1, 32'h0000_3003, 32'h1234_5678, 32'h0, 0, 0);
        do_txn(OP_ST, 3'd3, 32'h0000_3000, 32'h1, 32'h0, 0, 0);
        do_txn(OP_LD, 3'd7, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
        do_txn(OP_LD, 3'd5, 32'h0000_3006, 32'h0, 32'h8001_7FFF, 0, 0);
        do_txn(OP_ST, 3'd1, 32'h0000_3006, 32'hCAFE_BEEF, 32'h0, 1, 0);

        // Reset while waiting for load data; the late rvalid must vanish.
        do_txn(OP_OP, 3'd0, 32'h0000_0077, 32'h0, 32'h0, 0, 0);
        req_valid_i = 1'b1;
        opcode_i    = OP_LD;
        funct3_i    = 3'd2;
        addr_i      = 32'h0000_5000;
        step();
        req_valid_i = 1'b0;
        dmem_gnt_i  = 1'b1;
        step();
        dmem_gnt_i  = 1'b0;
        reset       = 1'b1;
        #1;
        chk("wrst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("wrst_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("wrst_req", {31'd0, dmem_req_o}, 32'd0);
        step();
        reset         = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEAD_BEEF;
        chk("wrst_idle", {31'd0, req_ready_o}, 32'd1);
        step();
        dmem_rvalid_i = 1'b0;
        chk("late_rv_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("late_rv_data", resp_data_o, 32'd0);
        chk("late_rv_err", {31'd0, err_o}, 32'd0);
        chk("late_rv_req", {31'd0, dmem_req_o}, 32'd0);
        step();
        chk("late_rv_valid2", {31'd0, resp_valid_o}, 32'd0);

        // Back-to-back SW then LW with valid held high throughout.
        y  = $urandom;
        g0 = n_gnt;
        req_valid_i  = 1'b1;
        opcode_i     = OP_ST;
        funct3_i     = 3'd2;
        addr_i       = 32'h0000_4000;
        store_data_i = 32'h0BAD_F00D;
        dmem_gnt_i   = 1'b1;
        step();
        opcode_i = OP_LD;
        chk("b2b_sw_req", {31'd0, dmem_req_o}, 32'd1);
        chk("b2b_sw_we", {31'd0, dmem_we_o}, 32'd1);
        chk("b2b_sw_wd", dmem_wdata_o, 32'h0BAD_F00D);
        chk("b2b_busy", {31'd0, req_ready_o}, 32'd0);
        step();
        chk("b2b_sw_resp", {31'd0, resp_valid_o}, 32'd1);
        chk("b2b_resp_busy", {31'd0, req_ready_o}, 32'd0);
        step();
        chk("b2b_accept_rdy", {31'd0, req_ready_o}, 32'd1);
        chk("b2b_gap_req", {31'd0, dmem_req_o}, 32'd0);
        step();
        req_valid_i = 1'b0;
        chk("b2b_lw_req", {31'd0, dmem_req_o}, 32'd1);
        chk("b2b_lw_we", {31'd0, dmem_we_o}, 32'd0);
        chk("b2b_lw_addr", dmem_addr_o, 32'h0000_4000);
        step();
        dmem_gnt_i    = 1'b0;
        chk("b2b_wait_req", {31'd0, dmem_req_o}, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = y;
        step();
        dmem_rvalid_i = 1'b0;
        chk("b2b_lw_resp", {31'd0, resp_valid_o}, 32'd1);
        chk("b2b_lw_data", resp_data_o, y);
        step();
        chk("b2b_end", {31'd0, resp_valid_o}, 32'd0);
        chk("b2b_ngnt", n_gnt - g0, 32'd2);

        // Randomized mix of instructions, widths, alignments and delays.
        for (int k = 0; k < 60; k++) begin
            case ($urandom % 4)
                0:       op = OP_LD;
                1:       op = OP_ST;
                2:       op = OP_OP;
                default: op = 7'h13;
            endcase
            a = $urandom;
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            do_txn(op, 3'($urandom), a, $urandom, $urandom,
                   int'($urandom % 4), int'($urandom % 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
